// File: rtl/ddr_axi_rd_arbiter.sv
// ddr_axi_rd_arbiter
// Shares one DDR AXI read slave port between two requesters (M0, M1).
// Exactly one burst is in flight at a time. Requesters are picked
// round-robin, and each returned burst is checked against the requested
// beat count.
//
// Ports (all in the DDR_SLAVE_CLK domain):
//   DDR_SLAVE_CLK, DDR_SLAVE_RST : clock, synchronous active-high reset
//   M0_*/M1_*                    : requester read address / data channels
//   S_*                          : DDR slave read address / data channels
//   GRANT                        : index of the current or last served requester
//   BUSY                         : arbiter is not idle
//   ERR_LEN                      : sticky beat-count error, cleared only by reset
module ddr_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              DDR_SLAVE_CLK,
  input  logic              DDR_SLAVE_RST,
  // requester 0
  input  logic [ID_W-1:0]   M0_RD_ADDR_ID,
  input  logic [ADDR_W-1:0] M0_RD_ADDR,
  input  logic [7:0]        M0_RD_ADDR_LEN,
  input  logic [1:0]        M0_RD_ADDR_BURST,
  input  logic              M0_RD_ADDR_VALID,
  output logic              M0_RD_ADDR_READY,
  output logic [ID_W-1:0]   M0_RD_BACK_ID,
  output logic [DATA_W-1:0] M0_RD_DATA,
  output logic [1:0]        M0_RD_DATA_RESP,
  output logic              M0_RD_DATA_LAST,
  output logic              M0_RD_DATA_VALID,
  input  logic              M0_RD_DATA_READY,
  // requester 1
  input  logic [ID_W-1:0]   M1_RD_ADDR_ID,
  input  logic [ADDR_W-1:0] M1_RD_ADDR,
  input  logic [7:0]        M1_RD_ADDR_LEN,
  input  logic [1:0]        M1_RD_ADDR_BURST,
  input  logic              M1_RD_ADDR_VALID,
  output logic              M1_RD_ADDR_READY,
  output logic [ID_W-1:0]   M1_RD_BACK_ID,
  output logic [DATA_W-1:0] M1_RD_DATA,
  output logic [1:0]        M1_RD_DATA_RESP,
  output logic              M1_RD_DATA_LAST,
  output logic              M1_RD_DATA_VALID,
  input  logic              M1_RD_DATA_READY,
  // DDR slave
  output logic [ID_W-1:0]   S_RD_ADDR_ID,
  output logic [ADDR_W-1:0] S_RD_ADDR,
  output logic [7:0]        S_RD_ADDR_LEN,
  output logic [1:0]        S_RD_ADDR_BURST,
  output logic              S_RD_ADDR_VALID,
  input  logic              S_RD_ADDR_READY,
  input  logic [ID_W-1:0]   S_RD_BACK_ID,
  input  logic [DATA_W-1:0] S_RD_DATA,
  input  logic [1:0]        S_RD_DATA_RESP,
  input  logic              S_RD_DATA_LAST,
  input  logic              S_RD_DATA_VALID,
  output logic              S_RD_DATA_READY,
  // status
  output logic              GRANT,
  output logic              BUSY,
  output logic              ERR_LEN
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;        // last served requester
  logic [ID_W-1:0] id_q, id_d;            // ID captured at the address handshake
  logic [7:0]      len_q, len_d;
  logic [8:0]      beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;

  // granted requester's channel, selected by grant_q
  logic [ID_W-1:0]   g_id_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic [7:0]        g_len_s;
  logic [1:0]        g_burst_s;
  logic              g_valid_s;
  logic              g_dready_s;
  logic              addr_hs_s;
  logic              data_hs_s;

  // The slave returns its own ID, but requesters receive the ID captured at
  // the address handshake, so S_RD_BACK_ID is intentionally unused.
  logic unused_back_id_s;
  assign unused_back_id_s = ^S_RD_BACK_ID;

  // Select the granted requester's channel signals
  always_comb begin
    if (grant_q) begin
      g_id_s     = M1_RD_ADDR_ID;
      g_addr_s   = M1_RD_ADDR;
      g_len_s    = M1_RD_ADDR_LEN;
      g_burst_s  = M1_RD_ADDR_BURST;
      g_valid_s  = M1_RD_ADDR_VALID;
      g_dready_s = M1_RD_DATA_READY;
    end else begin
      g_id_s     = M0_RD_ADDR_ID;
      g_addr_s   = M0_RD_ADDR;
      g_len_s    = M0_RD_ADDR_LEN;
      g_burst_s  = M0_RD_ADDR_BURST;
      g_valid_s  = M0_RD_ADDR_VALID;
      g_dready_s = M0_RD_DATA_READY;
    end
  end

  assign addr_hs_s = (state_q == ST_ADDR) & g_valid_s & S_RD_ADDR_READY;
  assign data_hs_s = (state_q == ST_DATA) & S_RD_DATA_VALID & g_dready_s;

  // Zero-latency channel muxes; everything idles at 0 outside its own phase
  always_comb begin
    S_RD_ADDR_ID     = '0;
    S_RD_ADDR        = '0;
    S_RD_ADDR_LEN    = 8'd0;
    S_RD_ADDR_BURST  = 2'd0;
    S_RD_ADDR_VALID  = 1'b0;
    S_RD_DATA_READY  = 1'b0;
    M0_RD_ADDR_READY = 1'b0;
    M1_RD_ADDR_READY = 1'b0;
    M0_RD_BACK_ID    = '0;
    M0_RD_DATA       = '0;
    M0_RD_DATA_RESP  = 2'd0;
    M0_RD_DATA_LAST  = 1'b0;
    M0_RD_DATA_VALID = 1'b0;
    M1_RD_BACK_ID    = '0;
    M1_RD_DATA       = '0;
    M1_RD_DATA_RESP  = 2'd0;
    M1_RD_DATA_LAST  = 1'b0;
    M1_RD_DATA_VALID = 1'b0;
    case (state_q)
      ST_ADDR: begin
        S_RD_ADDR_ID    = g_id_s;
        S_RD_ADDR       = g_addr_s;
        S_RD_ADDR_LEN   = g_len_s;
        S_RD_ADDR_BURST = g_burst_s;
        S_RD_ADDR_VALID = g_valid_s;
        if (grant_q) begin
          M1_RD_ADDR_READY = S_RD_ADDR_READY;
        end else begin
          M0_RD_ADDR_READY = S_RD_ADDR_READY;
        end
      end
      ST_DATA: begin
        S_RD_DATA_READY = g_dready_s;
        if (grant_q) begin
          M1_RD_BACK_ID    = id_q;
          M1_RD_DATA       = S_RD_DATA;
          M1_RD_DATA_RESP  = S_RD_DATA_RESP;
          M1_RD_DATA_LAST  = S_RD_DATA_LAST;
          M1_RD_DATA_VALID = S_RD_DATA_VALID;
        end else begin
          M0_RD_BACK_ID    = id_q;
          M0_RD_DATA       = S_RD_DATA;
          M0_RD_DATA_RESP  = S_RD_DATA_RESP;
          M0_RD_DATA_LAST  = S_RD_DATA_LAST;
          M0_RD_DATA_VALID = S_RD_DATA_VALID;
        end
      end
      default: begin
        S_RD_ADDR_VALID = 1'b0;
      end
    endcase
  end

  // Next-state logic: arbitration, burst capture and beat-count checking
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (M0_RD_ADDR_VALID | M1_RD_ADDR_VALID) begin
          state_d = ST_ADDR;
          if (M0_RD_ADDR_VALID & M1_RD_ADDR_VALID) begin
            grant_d = ~last_q;      // both asking: the one not served last wins
          end else begin
            grant_d = M1_RD_ADDR_VALID;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // a requester dropping VALID here is not re-arbitrated
        if (addr_hs_s) begin
          id_d       = g_id_s;
          len_d      = g_len_s;
          beat_cnt_d = 9'd0;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (data_hs_s) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (S_RD_DATA_LAST) begin
            // LAST must land exactly on beat len_q (counted from 0)
            if (beat_cnt_q != {1'b0, len_q}) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else if (beat_cnt_q == {1'b0, len_q}) begin
            // overrun: the expected last beat arrived without LAST
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge DDR_SLAVE_CLK) begin
    if (DDR_SLAVE_RST) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;       // makes M0 win the first contended arbitration
      id_q       <= '0;
      len_q      <= 8'd0;
      beat_cnt_q <= 9'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      id_q       <= id_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign GRANT   = grant_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign ERR_LEN = err_q;

endmodule

// File: tb/tb_ddr_axi_rd_arbiter.sv
// Self-checking bench for ddr_axi_rd_arbiter: a transaction-level model
// predicts every output each cycle, and directed scenarios add literal checks.
module tb_ddr_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // requester-side stimulus
  logic [IW-1:0] m_id     [0:1];
  logic [AW-1:0] m_addr   [0:1];
  logic [7:0]    m_len    [0:1];
  logic [1:0]    m_burst  [0:1];
  logic          m_valid  [0:1];
  logic          m_dready [0:1];
  // slave-side stimulus
  logic          s_aready;
  logic [IW-1:0] s_bid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_resp;
  logic          s_last;
  logic          s_dvalid;
  // DUT outputs
  logic m0_aready, m1_aready, m0_last, m1_last, m0_dvalid, m1_dvalid;
  logic [IW-1:0] m0_bid, m1_bid, s_aid;
  logic [DW-1:0] m0_data, m1_data;
  logic [1:0] m0_resp, m1_resp, s_burst;
  logic [AW-1:0] s_addr;
  logic [7:0] s_len;
  logic s_avalid, s_dready, grant, busy, err_len;

  ddr_axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .DDR_SLAVE_CLK(clk), .DDR_SLAVE_RST(rst),
    .M0_RD_ADDR_ID(m_id[0]), .M0_RD_ADDR(m_addr[0]), .M0_RD_ADDR_LEN(m_len[0]),
    .M0_RD_ADDR_BURST(m_burst[0]), .M0_RD_ADDR_VALID(m_valid[0]), .M0_RD_ADDR_READY(m0_aready),
    .M0_RD_BACK_ID(m0_bid), .M0_RD_DATA(m0_data), .M0_RD_DATA_RESP(m0_resp),
    .M0_RD_DATA_LAST(m0_last), .M0_RD_DATA_VALID(m0_dvalid), .M0_RD_DATA_READY(m_dready[0]),
    .M1_RD_ADDR_ID(m_id[1]), .M1_RD_ADDR(m_addr[1]), .M1_RD_ADDR_LEN(m_len[1]),
    .M1_RD_ADDR_BURST(m_burst[1]), .M1_RD_ADDR_VALID(m_valid[1]), .M1_RD_ADDR_READY(m1_aready),
    .M1_RD_BACK_ID(m1_bid), .M1_RD_DATA(m1_data), .M1_RD_DATA_RESP(m1_resp),
    .M1_RD_DATA_LAST(m1_last), .M1_RD_DATA_VALID(m1_dvalid), .M1_RD_DATA_READY(m_dready[1]),
    .S_RD_ADDR_ID(s_aid), .S_RD_ADDR(s_addr), .S_RD_ADDR_LEN(s_len), .S_RD_ADDR_BURST(s_burst),
    .S_RD_ADDR_VALID(s_avalid), .S_RD_ADDR_READY(s_aready),
    .S_RD_BACK_ID(s_bid), .S_RD_DATA(s_data), .S_RD_DATA_RESP(s_resp), .S_RD_DATA_LAST(s_last),
    .S_RD_DATA_VALID(s_dvalid), .S_RD_DATA_READY(s_dready),
    .GRANT(grant), .BUSY(busy), .ERR_LEN(err_len)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  int   own = -1;          // requester owning the port, -1 when idle
  bit   in_addr = 1'b0;    // owner still presenting its address
  logic [IW-1:0] cap_id = '0;
  int   beats = 0;         // beats accepted so far in this burst
  int   exp_len = 0;
  bit   m_err = 1'b0;
  int   m_last = 1;
  int   m_grant = 0;
  bit   model_ok = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      own = -1; in_addr = 1'b0; m_err = 1'b0; m_last = 1; m_grant = 0; model_ok = 1'b1;
    end else if (own < 0) begin
      if (m_valid[0] && m_valid[1]) own = 1 - m_last;
      else if (m_valid[0])          own = 0;
      else if (m_valid[1])          own = 1;
      if (own >= 0) begin m_grant = own; in_addr = 1'b1; end
    end else if (in_addr) begin
      if (m_valid[own] && s_aready) begin
        cap_id = m_id[own]; exp_len = int'(m_len[own]); beats = 0; in_addr = 1'b0;
      end
    end else if (s_dvalid && m_dready[own]) begin
      if (s_last) begin
        if (beats != exp_len) m_err = 1'b1;
        m_last = own; own = -1;
      end else begin
        if (beats == exp_len) m_err = 1'b1;
        beats++;
      end
    end
  end

  // compare every output against the model on every cycle after reset
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      bit ina, ind;
      int oi;
      ina = (own >= 0) && in_addr;
      ind = (own >= 0) && !in_addr;
      oi  = (own < 0) ? 0 : own;
      chk("busy", busy, own >= 0);
      chk("grant", grant, m_grant);
      chk("err_len", err_len, m_err);
      chk("s_avalid", s_avalid, ina ? m_valid[oi] : 1'b0);
      chk("s_addr", s_addr, ina ? m_addr[oi] : '0);
      chk("s_aid", s_aid, ina ? m_id[oi] : '0);
      chk("s_len", s_len, ina ? m_len[oi] : '0);
      chk("s_burst", s_burst, ina ? m_burst[oi] : '0);
      chk("s_dready", s_dready, ind ? m_dready[oi] : 1'b0);
      chk("m0_aready", m0_aready, (ina && oi == 0) ? s_aready : 1'b0);
      chk("m1_aready", m1_aready, (ina && oi == 1) ? s_aready : 1'b0);
      chk("m0_dvalid", m0_dvalid, (ind && oi == 0) ? s_dvalid : 1'b0);
      chk("m1_dvalid", m1_dvalid, (ind && oi == 1) ? s_dvalid : 1'b0);
      chk("m0_last", m0_last, (ind && oi == 0) ? s_last : 1'b0);
      chk("m1_last", m1_last, (ind && oi == 1) ? s_last : 1'b0);
      chk("m0_data", m0_data, (ind && oi == 0) ? s_data : '0);
      chk("m1_data", m1_data, (ind && oi == 1) ? s_data : '0);
      chk("m0_resp", m0_resp, (ind && oi == 0) ? s_resp : '0);
      chk("m1_resp", m1_resp, (ind && oi == 1) ? s_resp : '0);
      chk("m0_bid", m0_bid, (ind && oi == 0) ? cap_id : '0);
      chk("m1_bid", m1_bid, (ind && oi == 1) ? cap_id : '0);
    end
  end

  // ---------------- reactive DDR slave ----------------
  int   force_last = -1;   // >=0: assert LAST on this beat index instead
  bit   sl_pend = 1'b0;
  int   sl_total = 0;
  int   sl_idx = 0;
  int   s_ahs_cnt = 0;
  logic [AW-1:0] s_hs_addr = '0;
  logic [7:0]    s_hs_len = '0;

  initial forever begin
    bit ahs, dhs;
    logic [AW-1:0] a;
    logic [7:0] l;
    @(negedge clk);
    ahs = s_avalid && s_aready;
    dhs = s_dvalid && s_dready;
    a = s_addr; l = s_len;
    @(posedge clk);
    if (rst) begin
      sl_pend = 1'b0;
    end else begin
      if (dhs) begin
        sl_idx++;
        if (sl_idx == sl_total) sl_pend = 1'b0;
      end
      if (ahs) begin
        s_ahs_cnt++; s_hs_addr = a; s_hs_len = l;
        sl_pend = 1'b1; sl_idx = 0;
        sl_total = (force_last >= 0) ? force_last + 1 : int'(l) + 1;
      end
    end
    #1;
    s_dvalid = sl_pend;
    s_data   = 32'hA000_0000 + 32'(sl_idx);
    s_resp   = 2'(sl_idx);
    s_last   = sl_pend && (sl_idx == sl_total - 1);
    s_bid    = 4'hF;
  end

  // ---------------- requester-side observation ----------------
  int beats_cur [0:1] = '{0, 0};
  int burst_beats [0:1] = '{0, 0};
  int lowsum [0:1] = '{0, 0};
  logic [IW-1:0] bid_seen [0:1] = '{'0, '0};
  int order [$];
  int grant_at [$];
  bit m1_valid_seen = 1'b0;
  int stall_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      beats_cur = '{0, 0};
    end else begin
      for (int n = 0; n < 2; n++) begin
        logic dv, la, ar;
        logic [DW-1:0] d;
        logic [IW-1:0] b;
        dv = (n == 0) ? m0_dvalid : m1_dvalid;
        la = (n == 0) ? m0_last   : m1_last;
        ar = (n == 0) ? m0_aready : m1_aready;
        d  = (n == 0) ? m0_data   : m1_data;
        b  = (n == 0) ? m0_bid    : m1_bid;
        if (dv && m_dready[n]) begin
          beats_cur[n]++; bid_seen[n] = b; lowsum[n] += int'(d[7:0]);
          if (la) begin burst_beats[n] = beats_cur[n]; beats_cur[n] = 0; end
        end
        if (m_valid[n] && ar) begin order.push_back(n); grant_at.push_back(int'(grant)); end
      end
      if (m1_dvalid) m1_valid_seen = 1'b1;
      if (s_dvalid && !s_dready && busy) stall_cnt++;
    end
  end

  function automatic int qget(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int n, input logic [IW-1:0] id, input logic [AW-1:0] a,
                       input logic [7:0] len);
    int t;
    bit hs;
    t = 0; hs = 1'b0;
    m_id[n] = id; m_addr[n] = a; m_len[n] = len; m_burst[n] = 2'b01; m_valid[n] = 1'b1;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = (n == 0) ? m0_aready : m1_aready;
      t++;
    end
    if (!hs) timeout("addr_handshake");
    @(posedge clk); #1;
    m_valid[n] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || sl_pend || m_valid[0] || m_valid[1]) && t < 400);
    if (t >= 400) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n, input int k);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (beats_cur[n] < k && t < 200);
    if (t >= 200) timeout("wait_beats");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // watchdog so the run always ends
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_id[n] = '0; m_addr[n] = '0; m_len[n] = '0; m_burst[n] = '0;
      m_valid[n] = 1'b0; m_dready[n] = 1'b1;
    end
    s_aready = 1'b1; s_bid = '0; s_data = '0; s_resp = '0; s_last = 1'b0; s_dvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_err", err_len, 1'b0);
    chk("rst_s_avalid", s_avalid, 1'b0);

    // single M0 burst, slave holds off ADDR_READY for a few cycles
    @(posedge clk); #1;
    s_aready = 1'b0; s_ahs_cnt = 0; m1_valid_seen = 1'b0;
    fork
      issue(0, 4'd5, 32'h100, 8'd3);
      begin repeat (3) @(posedge clk); #1 s_aready = 1'b1; end
    join
    wait_idle();
    chk("t1_ahs_cnt", s_ahs_cnt, 1);
    chk("t1_addr", s_hs_addr, 32'h100);
    chk("t1_len", s_hs_len, 8'd3);
    chk("t1_beats", burst_beats[0], 4);
    chk("t1_bid", bid_seen[0], 4'd5);
    chk("t1_err", err_len, 1'b0);
    chk("t1_m1_valid", m1_valid_seen, 1'b0);

    // simultaneous requests straight after reset: M0 first, then M1
    pulse_reset();
    order.delete(); grant_at.delete();
    fork
      issue(0, 4'd1, 32'h200, 8'd0);
      issue(1, 4'd2, 32'h300, 8'd0);
    join
    wait_idle();
    chk("t2_order0", qget(order, 0), 0);
    chk("t2_order1", qget(order, 1), 1);
    chk("t2_grant0", qget(grant_at, 0), 0);
    chk("t2_grant1", qget(grant_at, 1), 1);
    chk("t2_m1_beats", burst_beats[1], 1);

    // M0 requests back to back, M1 once: M1 must get in between
    order.delete(); grant_at.delete();
    fork
      begin
        issue(0, 4'd3, 32'h1000, 8'd1);
        issue(0, 4'd4, 32'h1100, 8'd1);
        issue(0, 4'd6, 32'h1200, 8'd1);
      end
      issue(1, 4'd7, 32'h2000, 8'd2);
    join
    wait_idle();
    chk("t3_order0", qget(order, 0), 0);
    chk("t3_order1", qget(order, 1), 1);
    chk("t3_order2", qget(order, 2), 0);
    chk("t3_order3", qget(order, 3), 0);

    // early LAST on beat 2 of a LEN=3 burst sets the sticky error
    force_last = 1;
    issue(0, 4'd3, 32'h400, 8'd3);
    wait_idle();
    chk("t4_err", err_len, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_beats", burst_beats[0], 2);
    force_last = -1;
    issue(1, 4'd4, 32'h480, 8'd1);
    wait_idle();
    chk("t4_err_sticky", err_len, 1'b1);
    chk("t4_good_beats", burst_beats[1], 2);

    // requester stalls 5 cycles mid-burst
    lowsum[0] = 0; stall_cnt = 0;
    issue(0, 4'd7, 32'h500, 8'd7);
    wait_beats(0, 2);
    #1 m_dready[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 m_dready[0] = 1'b1;
    wait_idle();
    chk("t5_beats", burst_beats[0], 8);
    chk("t5_lowsum", lowsum[0], 28);
    chk("t5_stall", stall_cnt, 5);
    chk("t5_bid", bid_seen[0], 4'd7);

    // reset in the middle of a burst, then a fresh M1 request
    issue(0, 4'd8, 32'h600, 8'd7);
    wait_beats(0, 2);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err", err_len, 1'b0);
    chk("t6_grant", grant, 1'b0);
    chk("t6_s_avalid", s_avalid, 1'b0);
    chk("t6_s_dready", s_dready, 1'b0);
    chk("t6_m0_dvalid", m0_dvalid, 1'b0);
    chk("t6_m0_data", m0_data, 32'h0);
    order.delete(); grant_at.delete();
    issue(1, 4'd9, 32'h700, 8'd1);
    wait_idle();
    chk("t6_order", qget(order, 0), 1);
    chk("t6_grant_m1", qget(grant_at, 0), 1);
    chk("t6_m1_beats", burst_beats[1], 2);
    chk("t6_m1_bid", bid_seen[1], 4'd9);
    chk("t6_err_after", err_len, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_axi_rd_arbiter.md
Name: ddr_axi_rd_arbiter

Overview:
Two-master to one-slave arbiter for the DDR AXI read channel. It shares one DDR_SLAVE_RD_* port between two requesters, for example the frame reader and the host bridge. Only one burst is outstanding at a time, selection is round-robin, and the arbiter checks that each burst returns the requested number of beats. It sits between the requesters and the DDR AXI slave, in the DDR_SLAVE_CLK domain.

Parameters:
ADDR_W, 32, address width (all address ports)
DATA_W, 32, data width (all data ports)
ID_W, 4, AXI ID width (all ID ports)

Ports:
DDR_SLAVE_CLK  in  1  single clock for all logic
DDR_SLAVE_RST  in  1  synchronous, active-high reset
Mn_RD_ADDR_ID  in  ID_W  requester n (n=0,1) burst ID
Mn_RD_ADDR  in  ADDR_W  requester n start address
Mn_RD_ADDR_LEN  in  8  requester n beats minus 1
Mn_RD_ADDR_BURST  in  2  requester n burst type, passed through
Mn_RD_ADDR_VALID  in  1  requester n address valid
Mn_RD_ADDR_READY  out  1  requester n address accepted
Mn_RD_BACK_ID  out  ID_W  ID returned to requester n
Mn_RD_DATA  out  DATA_W  read data to requester n
Mn_RD_DATA_RESP  out  2  response to requester n
Mn_RD_DATA_LAST  out  1  last beat to requester n
Mn_RD_DATA_VALID  out  1  data valid to requester n
Mn_RD_DATA_READY  in  1  requester n data ready
S_RD_ADDR_ID / S_RD_ADDR / S_RD_ADDR_LEN / S_RD_ADDR_BURST / S_RD_ADDR_VALID  out  ID_W / ADDR_W / 8 / 2 / 1  to DDR slave
S_RD_ADDR_READY  in  1  from DDR slave
S_RD_BACK_ID / S_RD_DATA / S_RD_DATA_RESP / S_RD_DATA_LAST / S_RD_DATA_VALID  in  ID_W / DATA_W / 2 / 1 / 1  from DDR slave
S_RD_DATA_READY  out  1  to DDR slave
GRANT  out  1  index of the currently or last served requester
BUSY  out  1  high when the state is not IDLE
ERR_LEN  out  1  sticky beat-count error flag

Behaviour:
- Clocking and reset: single clock DDR_SLAVE_CLK; DDR_SLAVE_RST is synchronous and active-high.
- State machine: IDLE, ADDR, DATA.
- IDLE:
  - If either Mn_RD_ADDR_VALID is high, register the grant and go to ADDR on the next edge.
  - Both requesting: take the requester other than the last served one. After reset, M0 wins.
  - Nothing requesting: stay in IDLE.
- ADDR:
  - S_RD_ADDR_* is muxed combinationally from the granted requester.
  - S_RD_ADDR_VALID = granted Mn_RD_ADDR_VALID.
  - Granted Mn_RD_ADDR_READY = S_RD_ADDR_READY. The non-granted READY is 0.
  - On handshake: capture ID, capture LEN into len_q, clear beat_cnt, go to DATA.
  - Requesters hold their address stable until the handshake, as AXI requires.
- DATA:
  - Granted Mn_RD_DATA_VALID = S_RD_DATA_VALID; DATA, RESP and LAST are passed through.
  - Mn_RD_BACK_ID = captured ID, not S_RD_BACK_ID.
  - S_RD_DATA_READY = granted Mn_RD_DATA_READY.
  - The non-granted requester sees VALID=0 and LAST=0.
  - beat_cnt (9 bits) increments on each data handshake.
  - On the handshake with LAST=1: if beat_cnt != len_q, set ERR_LEN. Then go to IDLE and mark this requester as last served.
  - On a handshake with LAST=0 and beat_cnt == len_q (overrun): set ERR_LEN and stay in DATA.
- Timing:
  - Minimum one IDLE cycle between bursts.
  - Zero added latency on the address and data paths; all paths are combinational muxes.
- A requester dropping VALID while in ADDR: the arbiter stays in ADDR; there is no re-arbitration.
- LEN=0: a single beat with LAST is legal and sets no error.
- Reset values and reset mid-burst:
  - State = IDLE, GRANT = 0, last-served = M1 (so M0 wins first), ERR_LEN = 0, BUSY = 0.
  - All READY and VALID outputs = 0; ID/DATA outputs 0.
  - An in-flight slave burst is abandoned; the slave is reset by the same system reset.
- ERR_LEN clears only on reset.

Test Plan:
- Single M0 read, ADDR=0x100, LEN=3, ID=5 -> exactly one S ADDR handshake with ADDR=0x100 and LEN=3; M0 receives 4 beats with BACK_ID=5 and LAST on beat 4; ERR_LEN=0; M1_RD_DATA_VALID stays 0.
- M0 and M1 request in the same cycle after reset, LEN=0 each -> M0 served first, then M1 after one IDLE cycle; GRANT goes 0 then 1.
- M0 requests continuously, M1 requests once -> order is M0, M1, M0 (no starvation).
- Slave asserts LAST on beat 2 of a LEN=3 burst -> ERR_LEN=1, arbiter returns to IDLE; a second, correct burst leaves ERR_LEN=1.
- Granted requester deasserts DATA_READY for 5 cycles mid-burst -> S_RD_DATA_READY=0 for those cycles; no beat lost or duplicated; beat_cnt is correct.
- DDR_SLAVE_RST asserted for 1 cycle during DATA -> next cycle BUSY=0, all VALID/READY outputs 0, ERR_LEN=0; a new M1-only request is granted normally.
